// File: rtl/collision_checker.sv
// Sequential obstacle-vs-T-rex overlap scanner: one slot per cycle through a single
// box comparator, raising a sticky crash flag with the index of the first hit slot.

module box_hit #(
    parameter int MARGIN = 2
) (
    input  logic        active_i,
    input  logic [10:0] x_pos_i,
    input  logic [9:0]  y_pos_i,
    input  logic [9:0]  width_i,
    input  logic [9:0]  height_i,
    input  logic [9:0]  tx_i,
    input  logic [9:0]  ty_i,
    input  logic [9:0]  tw_i,
    input  logic [9:0]  th_i,
    output logic        hit_o
);
    localparam logic signed [11:0] M  = 12'(MARGIN);
    localparam logic signed [11:0] M2 = 12'(2 * MARGIN);

    logic signed [11:0] ox, oy, ow, oh, w, h, tx, ty, tw, th;

    // x_pos is the only signed input (obstacles slide off the left edge)
    assign ox = $signed({x_pos_i[10], x_pos_i}) + M;
    assign oy = $signed({2'b00, y_pos_i}) + M;
    assign w  = $signed({2'b00, width_i});
    assign h  = $signed({2'b00, height_i});
    assign ow = w - M2;
    assign oh = h - M2;
    assign tx = $signed({2'b00, tx_i});
    assign ty = $signed({2'b00, ty_i});
    assign tw = $signed({2'b00, tw_i});
    assign th = $signed({2'b00, th_i});

    assign hit_o = active_i && (w > M2) && (h > M2)
                && (ox < tx + tw) && (tx < ox + ow)
                && (oy < ty + th) && (ty < oy + oh);
endmodule

module collision_checker #(
    parameter int N_OBS  = 7,
    parameter int MARGIN = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   check,
    input  logic                   clear,
    input  logic [9:0]             trex_x,
    input  logic [9:0]             trex_y,
    input  logic [9:0]             trex_w,
    input  logic [9:0]             trex_h,
    input  logic [N_OBS-1:0]       obstacle_start,
    input  logic [N_OBS-1:0][10:0] obstacle_x_pos,
    input  logic [N_OBS-1:0][9:0]  obstacle_y_pos,
    input  logic [N_OBS-1:0][9:0]  obstacle_width,
    input  logic [N_OBS-1:0][9:0]  obstacle_height,
    output logic                   busy,
    output logic                   done,
    output logic                   crash,
    output logic [2:0]             hit_index
);
    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_e;
    localparam logic [2:0] LAST = 3'(N_OBS - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic       crash_q, crash_d;
    logic [2:0] hit_q, hit_d;
    logic [9:0] tx_q, ty_q, tw_q, th_q;
    logic [9:0] tx_d, ty_d, tw_d, th_d;
    logic       slot_hit;

    box_hit #(.MARGIN(MARGIN)) u_cmp (
        .active_i (obstacle_start[idx_q]),
        .x_pos_i  (obstacle_x_pos[idx_q]),
        .y_pos_i  (obstacle_y_pos[idx_q]),
        .width_i  (obstacle_width[idx_q]),
        .height_i (obstacle_height[idx_q]),
        .tx_i     (tx_q),
        .ty_i     (ty_q),
        .tw_i     (tw_q),
        .th_i     (th_q),
        .hit_o    (slot_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            crash_q <= 1'b0;
            hit_q   <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            tw_q    <= '0;
            th_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            crash_q <= crash_d;
            hit_q   <= hit_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tw_q    <= tw_d;
            th_q    <= th_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        crash_d = crash_q;
        hit_d   = hit_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        tw_d    = tw_q;
        th_d    = th_q;
        case (state_q)
            IDLE: begin
                if (check && !crash_q) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    tx_d    = trex_x;
                    ty_d    = trex_y;
                    tw_d    = trex_w;
                    th_d    = trex_h;
                end
            end
            SCAN: begin
                if (slot_hit) begin
                    crash_d = 1'b1;
                    hit_d   = idx_q;
                    state_d = FINISH;
                end else if (idx_q == LAST) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // clear wins over a same-cycle check and aborts any scan
        if (clear) begin
            crash_d = 1'b0;
            hit_d   = '0;
            state_d = IDLE;
        end
    end

    // busy/done decode straight from the registered state, so they stay glitch-free
    assign busy      = (state_q == SCAN);
    assign done      = (state_q == FINISH);
    assign crash     = crash_q;
    assign hit_index = hit_q;
endmodule
